// File: rtl/uart2apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart2apb_pkg
// Description : Shared constants for the UART-to-APB bridge: byte width,
//               default receive-FIFO depth and status-register bit placement.
// Revision    : 1.0 - initial release
// ============================================================================
package uart2apb_pkg;

    // Width of one UART character
    localparam int UART_BYTE_W            = 8;

    // Default receive FIFO depth (log2 of entry count)
    localparam int FIFO_DEPTH_LOG2_DEFAULT = 4;

    // Status register layout used by the command decoder
    localparam int STAT_OVERFLOW_BIT      = 0;
    localparam int STAT_UNDERFLOW_BIT     = 1;
    localparam int STAT_AFULL_BIT         = 2;
    localparam int STAT_LEVEL_LSB         = 8;

endpackage : uart2apb_pkg
`default_nettype wire

// File: rtl/uart_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ptr
// Description : FIFO pointer register with natural binary wrap. One extra
//               MSB beyond the address bits distinguishes full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_ptr #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] C_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] r_ptr;

    // Advance by one on each accepted transfer, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + C_ONE;
        end
    end

    assign ptr = r_ptr;

endmodule : uart_fifo_ptr
`default_nettype wire

// File: rtl/uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_fifo
// Description : First-word-fall-through byte FIFO between the UART receiver
//               and the command decoder. Provides fill level and sticky
//               overflow/underflow flags.
//               Optional feature macro: UART_RX_FIFO_AFULL_EN adds the
//               registered almost_full output and the AFULL_LEVEL parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte_fifo
    import uart2apb_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEFAULT
`ifdef UART_RX_FIFO_AFULL_EN
   ,parameter int AFULL_LEVEL = 12
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   wr_req,
    output logic                   wr_ready,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   rd_valid,
    input  logic                   rd_req,
    output logic [DEPTH_LOG2:0]    level,
    input  logic                   flag_clr,
    output logic                   overflow,
    output logic                   underflow
`ifdef UART_RX_FIFO_AFULL_EN
   ,output logic                   almost_full
`endif
);

    localparam int               C_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [UART_BYTE_W-1:0] r_mem [C_DEPTH];
    logic [DEPTH_LOG2:0]    w_wr_ptr;
    logic [DEPTH_LOG2:0]    w_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic [DEPTH_LOG2:0]    w_level_next;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   r_overflow;
    logic                   r_underflow;

    // Full/empty come from registered pointers only, so a pop in the same
    // cycle never frees room for a write that is being rejected.
    assign w_empty  = (w_wr_ptr == w_rd_ptr);
    assign w_full   = (w_wr_ptr[DEPTH_LOG2-1:0] == w_rd_ptr[DEPTH_LOG2-1:0]) &&
                      (w_wr_ptr[DEPTH_LOG2] != w_rd_ptr[DEPTH_LOG2]);
    assign w_wr_acc = wr_req && !w_full;
    assign w_rd_acc = rd_req && !w_empty;

    uart_fifo_ptr #(.PTR_W(DEPTH_LOG2 + 1)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_acc),
        .ptr (w_wr_ptr)
    );

    uart_fifo_ptr #(.PTR_W(DEPTH_LOG2 + 1)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_acc),
        .ptr (w_rd_ptr)
    );

    // Storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Next fill level: moves only when exactly one side is accepted
    always_comb begin
        w_level_next = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_next = r_level + C_LVL_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_next = r_level - C_LVL_ONE;
        end
    end

    // Registered fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_req && w_full)  || (r_overflow  && !flag_clr);
            r_underflow <= (rd_req && w_empty) || (r_underflow && !flag_clr);
        end
    end

`ifdef UART_RX_FIFO_AFULL_EN
    logic r_almost_full;

    // Threshold on the updated level so it tracks level in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (int'(w_level_next) >= AFULL_LEVEL);
        end
    end

    assign almost_full = r_almost_full;
`endif

    assign wr_ready  = !w_full;
    assign rd_valid  = !w_empty;
    assign rd_data   = r_mem[w_rd_ptr[DEPTH_LOG2-1:0]];
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : uart_rx_byte_fifo
`default_nettype wire

// File: tb/tb_uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte_fifo
// Description : Directed self-checking bench for uart_rx_byte_fifo
//               (DEPTH_LOG2 = 4). Almost-full checks are included when
//               UART_RX_FIFO_AFULL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_req;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_req;
    logic [4:0] level;
    logic       flag_clr;
    logic       overflow;
    logic       underflow;
`ifdef UART_RX_FIFO_AFULL_EN
    logic       almost_full;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    uart_rx_byte_fifo #(.DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_req      (wr_req),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_req      (rd_req),
        .level       (level),
        .flag_clr    (flag_clr),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef UART_RX_FIFO_AFULL_EN
       ,.almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_data = 8'h00; wr_req = 1'b0; rd_req = 1'b0; flag_clr = 1'b0;
        tick(); tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
`ifdef UART_RX_FIFO_AFULL_EN
        chk("rst_almost_full", almost_full, 0);
`endif
        rst = 1'b0;
        tick();

        // Three consecutive writes then three pops
        wr_req = 1'b1; wr_data = 8'h41; tick();
        chk("w1_rd_valid", rd_valid, 1);
        chk("w1_rd_data", rd_data, 8'h41);
        chk("w1_level", level, 1);
        wr_data = 8'h42; tick();
        chk("w2_level", level, 2);
        chk("w2_head", rd_data, 8'h41);
        wr_data = 8'h43; tick();
        chk("w3_level", level, 3);
        wr_req = 1'b0; rd_req = 1'b1; tick();
        chk("p1_rd_data", rd_data, 8'h42);
        chk("p1_level", level, 2);
        tick();
        chk("p2_rd_data", rd_data, 8'h43);
        tick();
        chk("p3_rd_valid", rd_valid, 0);
        chk("p3_level", level, 0);
        rd_req = 1'b0;

        // Fill to 16, then overflow attempt with 0xFF
        wr_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h10 + 8'(i);
            tick();
        end
        chk("full_wr_ready", wr_ready, 0);
        chk("full_level", level, 16);
        chk("full_no_ovf_yet", overflow, 0);
        wr_data = 8'hFF; tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 16);
        wr_req = 1'b0; flag_clr = 1'b1; tick();
        chk("ovf_clr", overflow, 0);
        flag_clr = 1'b0;

        // Full: simultaneous write 0x55 and pop
        chk("full_head", rd_data, 8'h10);
        wr_req = 1'b1; wr_data = 8'h55; rd_req = 1'b1; tick();
        chk("fullrw_ovf", overflow, 1);
        chk("fullrw_level", level, 15);
        chk("fullrw_wr_ready", wr_ready, 1);
        wr_req = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", rd_data, 8'h10 + 8'(i));
            tick();
        end
        chk("drain_rd_valid", rd_valid, 0);
        chk("drain_level", level, 0);
        rd_req = 1'b0; flag_clr = 1'b1; tick();
        flag_clr = 1'b0;
        chk("drain_ovf_clr", overflow, 0);
        chk("drain_no_udf", underflow, 0);

        // Empty: simultaneous write 0x5A and pop
        wr_req = 1'b1; wr_data = 8'h5A; rd_req = 1'b1; tick();
        chk("emptyrw_udf", underflow, 1);
        chk("emptyrw_level", level, 1);
        chk("emptyrw_rd_data", rd_data, 8'h5A);
        wr_req = 1'b0; rd_req = 1'b0; flag_clr = 1'b1; tick();
        chk("udf_clr", underflow, 0);
        chk("udf_clr_level", level, 1);
        flag_clr = 1'b0;
        q.push_back(8'h5A);

        // Bring level to 8, then 40 cycles of simultaneous write and pop
        wr_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h60 + 8'(i);
            q.push_back(wr_data);
            tick();
        end
        chk("half_level", level, 8);
        rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'h80 + 8'(i);
            chk("stream_data", rd_data, q[0]);
            void'(q.pop_front());
            q.push_back(wr_data);
            tick();
            chk("stream_level", level, 8);
        end
        wr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("stream_drain", rd_data, q[0]);
            void'(q.pop_front());
            tick();
        end
        chk("stream_empty", rd_valid, 0);
        chk("stream_no_udf", underflow, 0);

        // Clear and underflow in the same cycle: set wins
        flag_clr = 1'b1; tick();
        chk("clr_vs_set", underflow, 1);
        rd_req = 1'b0; tick();
        chk("clr_after", underflow, 0);
        flag_clr = 1'b0;

`ifdef UART_RX_FIFO_AFULL_EN
        // almost_full threshold at 12
        wr_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wr_data = 8'(i); tick();
        end
        chk("af_level11", level, 11);
        chk("af_low", almost_full, 0);
        tick();
        chk("af_level12", level, 12);
        chk("af_high", almost_full, 1);
        wr_req = 1'b0; rd_req = 1'b1; tick();
        rd_req = 1'b0;
        chk("af_pop_level", level, 11);
        chk("af_fall", almost_full, 0);
`endif

        // Reset in the middle of traffic
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'hC0 + 8'(i); tick();
        end
        chk("pre_rst_valid", rd_valid, 1);
        wr_req = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_wr_ready", wr_ready, 1);
`ifdef UART_RX_FIFO_AFULL_EN
        chk("mid_rst_af", almost_full, 0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_byte_fifo
`default_nettype wire
